// File: rtl/router_pkt_rx_if.sv
// Byte-stream bus between the network source, the receive stage and the three output FIFOs.
// A byte moves on a rising edge where pkt_valid && !busy; the source holds data_in while busy.
interface router_pkt_rx_if;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic       busy;
    logic [2:0] write_enb;
    logic [7:0] fifo_data;

    modport master (
        output pkt_valid,
        output data_in,
        output fifo_full,
        input  busy,
        input  write_enb,
        input  fifo_data
    );

    modport slave (
        input  pkt_valid,
        input  data_in,
        input  fifo_full,
        output busy,
        output write_enb,
        output fifo_data
    );
endinterface

// File: rtl/router_pkt_rx.sv
// Router receive stage: decodes the header, steers bytes into the addressed FIFO,
// checks packet parity, drops packets for the invalid port and keeps status counters.
module router_pkt_rx #(
    parameter int NUM_PORTS = 3
) (
    input  logic              clk,
    input  logic              reset,
    router_pkt_rx_if.slave    bus,
    output logic              err,
    output logic              pkt_done,
    output logic [15:0]       pkt_cnt,
    output logic [7:0]        err_cnt,
    output logic [7:0]        drop_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [1:0] BAD_ADDR = 2'(NUM_PORTS);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [5:0]  rem_q, rem_d;
    logic [7:0]  par_q, par_d;
    logic        err_q, err_d;
    logic        pkt_done_q, pkt_done_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        busy_c;
    logic        accept_c;
    logic [2:0]  write_enb_c;
    logic [1:0]  hdr_addr;
    logic [5:0]  hdr_len;

    assign hdr_addr = bus.data_in[1:0];
    assign hdr_len  = bus.data_in[7:2];

    // Port code 3 has no FIFO, so it never reports full.
    function automatic logic port_full(input logic [1:0] a, input logic [2:0] f);
        case (a)
            2'd0:    port_full = f[0];
            2'd1:    port_full = f[1];
            2'd2:    port_full = f[2];
            default: port_full = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rem_d       = rem_q;
        par_d       = par_q;
        err_d       = err_q;
        pkt_done_d  = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        busy_c      = 1'b0;
        write_enb_c = 3'b000;

        case (state_q)
            IDLE:            busy_c = bus.pkt_valid && (hdr_addr != BAD_ADDR) &&
                                      port_full(hdr_addr, bus.fifo_full);
            PAYLOAD, PARITY: busy_c = port_full(sel_q, bus.fifo_full);
            default:         busy_c = 1'b0;
        endcase

        accept_c = bus.pkt_valid && !busy_c;

        if (accept_c) begin
            case (state_q)
                IDLE: begin
                    rem_d = hdr_len;
                    if (hdr_addr != BAD_ADDR) begin
                        write_enb_c = 3'(3'b001 << hdr_addr);
                        sel_d       = hdr_addr;
                        par_d       = bus.data_in;
                        err_d       = 1'b0;
                        state_d     = (hdr_len != 6'd0) ? PAYLOAD : PARITY;
                    end else begin
                        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                        state_d = DROP;
                    end
                end
                PAYLOAD: begin
                    write_enb_c = 3'(3'b001 << sel_q);
                    par_d       = par_q ^ bus.data_in;
                    rem_d       = rem_q - 6'd1;
                    if (rem_q == 6'd1) state_d = PARITY;
                end
                PARITY: begin
                    write_enb_c = 3'(3'b001 << sel_q);
                    err_d       = (par_q != bus.data_in);
                    pkt_done_d  = 1'b1;
                    pkt_cnt_d   = pkt_cnt_q + 16'd1;
                    if ((par_q != bus.data_in) && (err_cnt_q != 8'hFF))
                        err_cnt_d = err_cnt_q + 8'd1;
                    state_d = IDLE;
                end
                default: begin
                    // rem reaching zero means this byte is the dropped packet's parity.
                    if (rem_q == 6'd0) state_d = IDLE;
                    else               rem_d   = rem_q - 6'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            rem_q      <= 6'd0;
            par_q      <= 8'd0;
            err_q      <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_cnt_q  <= 16'd0;
            err_cnt_q  <= 8'd0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rem_q      <= rem_d;
            par_q      <= par_d;
            err_q      <= err_d;
            pkt_done_q <= pkt_done_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.busy      = busy_c;
    assign bus.write_enb = write_enb_c;
    assign bus.fifo_data = bus.data_in;

    assign err       = err_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_router_pkt_rx.sv
// Bench for router_pkt_rx: byte-position reference model checked every cycle,
// directed packets from the test plan, then randomized traffic with stalls and gaps.
module tb_router_pkt_rx;

    logic        clk;
    logic        reset;
    logic        err;
    logic        pkt_done;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;
    logic [1:0]  dbg_state;

    router_pkt_rx_if bus ();

    router_pkt_rx #(.NUM_PORTS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .err       (err),
        .pkt_done  (pkt_done),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt),
        .drop_cnt  (drop_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_left counts bytes still owed by the current packet, parity included; 0 = waiting for header.
    int          m_left = 0;
    logic [1:0]  m_addr = 2'd0;
    logic [7:0]  m_par = 8'd0;
    logic        m_err = 1'b0;
    logic        m_done = 1'b0;
    int          m_pkt_cnt = 0;
    int          m_err_cnt = 0;
    int          m_drop_cnt = 0;
    int          wr_cnt [3] = '{0, 0, 0};
    int          busy_cycles = 0;

    function automatic logic full_of(input logic [1:0] a, input logic [2:0] f);
        if (a == 2'd3) return 1'b0;
        return f[a];
    endfunction

    always @(negedge clk) begin
        logic [1:0] a;
        logic       exp_busy;
        logic       acc;
        logic [2:0] exp_we;
        if (reset) begin
            m_left = 0; m_addr = 0; m_par = 0; m_err = 0; m_done = 0;
            m_pkt_cnt = 0; m_err_cnt = 0; m_drop_cnt = 0;
        end
        a = (m_left == 0) ? bus.data_in[1:0] : m_addr;
        if (m_left == 0) exp_busy = bus.pkt_valid && (a != 2'd3) && full_of(a, bus.fifo_full);
        else             exp_busy = full_of(a, bus.fifo_full);
        acc    = bus.pkt_valid && !exp_busy;
        exp_we = (acc && a != 2'd3) ? 3'(3'b001 << a) : 3'b000;

        check("busy",      32'(bus.busy),      32'(exp_busy));
        check("write_enb", 32'(bus.write_enb), 32'(exp_we));
        check("fifo_data", 32'(bus.fifo_data), 32'(bus.data_in));
        check("err",       32'(err),           32'(m_err));
        check("pkt_done",  32'(pkt_done),      32'(m_done));
        check("pkt_cnt",   32'(pkt_cnt),       32'(m_pkt_cnt % 65536));
        check("err_cnt",   32'(err_cnt),       32'(m_err_cnt));
        check("drop_cnt",  32'(drop_cnt),      32'(m_drop_cnt));

        for (int i = 0; i < 3; i++) if (bus.write_enb[i]) wr_cnt[i]++;
        if (bus.busy) busy_cycles++;

        m_done = 1'b0;
        if (!reset && acc) begin
            if (m_left == 0) begin
                m_addr = a;
                m_left = int'(bus.data_in[7:2]) + 1;
                m_par  = bus.data_in;
                if (a != 2'd3) m_err = 1'b0;
                else if (m_drop_cnt < 255) m_drop_cnt++;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_addr != 2'd3) begin
                        m_done = 1'b1;
                        m_err  = (m_par != bus.data_in);
                        m_pkt_cnt++;
                        if (m_err && m_err_cnt < 255) m_err_cnt++;
                    end
                end else begin
                    m_par = m_par ^ bus.data_in;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    logic [7:0] pkt_q [$];
    bit rand_full = 0;
    bit gap_en = 0;
    int stall_left = 0;

    task automatic drive_full();
        if (stall_left > 0) begin
            bus.fifo_full = 3'b100;
            stall_left--;
        end else if (rand_full) begin
            for (int i = 0; i < 3; i++) bus.fifo_full[i] = ($urandom_range(0, 3) == 0);
        end else begin
            bus.fifo_full = 3'b000;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte's accept edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.pkt_valid = 1'b1;
        bus.data_in   = b;
        drive_full();
        forever begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'(n), 32'd0);
                break;
            end
            @(posedge clk); #1;
            drive_full();
        end
        @(posedge clk); #1;
        bus.pkt_valid = 1'b0;
    endtask

    task automatic idle_gap();
        int g;
        g = gap_en ? $urandom_range(0, 2) : 0;
        repeat (g) begin
            bus.data_in = 8'($urandom);
            drive_full();
            @(posedge clk); #1;
        end
    endtask

    task automatic send_pkt();
        foreach (pkt_q[i]) begin
            send_byte(pkt_q[i]);
            idle_gap();
        end
    endtask

    task automatic build_pkt(input logic [1:0] addr, input int len, input bit corrupt);
        logic [7:0] b;
        logic [7:0] p;
        pkt_q.delete();
        p = {6'(len), addr};
        pkt_q.push_back(p);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            p = p ^ b;
            pkt_q.push_back(b);
        end
        pkt_q.push_back(corrupt ? (p ^ 8'($urandom_range(1, 255))) : p);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pkt_valid = 1'b0;
        @(negedge clk);
        check("rst_state",    32'(dbg_state), 32'd0);
        check("rst_pkt_cnt",  32'(pkt_cnt),   32'd0);
        check("rst_drop_cnt", 32'(drop_cnt),  32'd0);
        check("rst_err_cnt",  32'(err_cnt),   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int w0, w1, w2;

    initial begin
        reset = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.data_in   = 8'h00;
        bus.fifo_full = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Good packet: addr 1, len 3; parity = 0D^11^22^33 = 0D.
        w1 = wr_cnt[1];
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_pkt();
        @(negedge clk);
        check("t1_done",    32'(pkt_done),      32'd1);
        check("t1_err",     32'(err),           32'd0);
        check("t1_pkt_cnt", 32'(pkt_cnt),       32'd1);
        check("t1_writes",  32'(wr_cnt[1] - w1), 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_done_pulse", 32'(pkt_done), 32'd0);
        @(posedge clk); #1;

        // Same packet with bad parity.
        w1 = wr_cnt[1];
        pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        send_pkt();
        @(negedge clk);
        check("t2_err",     32'(err),            32'd1);
        check("t2_err_cnt", 32'(err_cnt),        32'd1);
        check("t2_writes",  32'(wr_cnt[1] - w1), 32'd5);
        @(posedge clk); #1;

        // Stall on FIFO 2 for four cycles during payload; err clears on this header.
        w2 = wr_cnt[2];
        build_pkt(2'd2, 3, 1'b0);
        send_byte(pkt_q[0]);
        @(negedge clk);
        check("t3_err_clear", 32'(err), 32'd0);
        @(posedge clk); #1;
        busy_cycles = 0;
        stall_left = 4;
        for (int i = 1; i < 5; i++) send_byte(pkt_q[i]);
        check("t3_busy_cycles", 32'(busy_cycles),     32'd4);
        check("t3_writes",      32'(wr_cnt[2] - w2),  32'd5);
        check("t3_pkt_cnt",     32'(pkt_cnt),         32'd3);

        // Dropped addr-3 packet, then a back-to-back addr-0 len-0 packet.
        w0 = wr_cnt[0]; w1 = wr_cnt[1]; w2 = wr_cnt[2];
        pkt_q = '{8'h0B, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h00};
        send_pkt();
        @(negedge clk);
        check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
        check("t4_done",     32'(pkt_done), 32'd1);
        check("t4_w0",       32'(wr_cnt[0] - w0), 32'd2);
        check("t4_w12",      32'((wr_cnt[1] - w1) + (wr_cnt[2] - w2)), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a len-5 packet, then a fresh len-0 packet to port 1.
        build_pkt(2'd0, 5, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(pkt_q[i]);
        do_reset();
        w1 = wr_cnt[1];
        pkt_q = '{8'h01, 8'h01};
        send_pkt();
        @(negedge clk);
        check("t5_done",    32'(pkt_done),       32'd1);
        check("t5_pkt_cnt", 32'(pkt_cnt),        32'd1);
        check("t5_writes",  32'(wr_cnt[1] - w1), 32'd2);
        @(posedge clk); #1;

        // 256 parity-error packets with random stalls and gaps.
        do_reset();
        rand_full = 1;
        gap_en = 1;
        for (int k = 0; k < 256; k++) begin
            build_pkt(2'($urandom_range(0, 2)), $urandom_range(0, 3), 1'b1);
            send_pkt();
        end
        @(negedge clk);
        check("t6_err_cnt_sat", 32'(err_cnt), 32'd255);
        check("t6_pkt_cnt",     32'(pkt_cnt), 32'd256);
        check("t6_err",         32'(err),     32'd1);
        @(posedge clk); #1;

        // Random mix including dropped packets and good parity.
        for (int k = 0; k < 60; k++) begin
            build_pkt(2'($urandom_range(0, 3)), $urandom_range(0, 10), ($urandom_range(0, 3) == 0));
            send_pkt();
        end
        rand_full = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
